simple_adder: RTL and testbench
===============================

Name: simple_adder

Overview:
- Registered two's-complement adder: out = a + b, with carry, signed-overflow and zero flags.
- Two-stage pipeline: stage 1 adds the low half; stage 2 adds the high half using the stage-1 carry.
- Throughput one operation per cycle; no backpressure.
- Generic arithmetic building block for datapath and ALU-support logic in the pipelined processor.

Parameters:
- WIDTH, 32, operand and result width; must be even and at least 2.
- LO_WIDTH, WIDTH/2, width of the stage-1 low slice; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a and b are sampled at this edge when high.
- a  input  WIDTH  operand A, unsigned or two's-complement.
- b  input  WIDTH  operand B, unsigned or two's-complement.
- out_valid  output  1  out and the flags carry a new result this cycle.
- out  output  WIDTH  sum, a + b mod 2^WIDTH.
- carry  output  1  unsigned carry-out of bit WIDTH-1.
- overflow  output  1  signed overflow: operands share a sign and the sum's sign differs.
- zero  output  1  out == 0.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): all pipeline registers, out_valid, out, carry, overflow and zero go to 0.
- Reset released mid-operation: in-flight operations are discarded and no spurious out_valid is produced.
- Stage 1, on an edge with in_valid=1:
  - register lo_sum = a[LO-1:0] + b[LO-1:0] and carry c1;
  - register a_hi and b_hi;
  - set v1=1.
- Stage 1, on an edge with in_valid=0: v1 goes to 0; data registers may hold.
- Stage 2, on an edge with v1=1:
  - hi_sum = a_hi + b_hi + c1;
  - out = {hi_sum, lo_sum};
  - carry = carry-out of hi_sum;
  - overflow = (a_hi[msb]==b_hi[msb]) && (out[msb]!=a_hi[msb]);
  - zero = (out==0);
  - out_valid = 1.
- Stage 2, on an edge with v1=0: out_valid goes to 0; out and the flags hold their last values.
- Latency: result appears exactly 2 rising edges after the sampling edge. Back-to-back inputs produce back-to-back outputs in order.
- Wrap-around: the sum is modulo 2^WIDTH. Example: 0xFFFFFFFF+1 gives out=0, carry=1, zero=1, overflow=0.
- No state machine; the pipeline consists only of the valid bits v1 and out_valid.

Optional Feature:
- Macro SIMPLE_ADDER_SAT_EN.
- Defined: signed saturation. On overflow, out = 0x7FFF..F when both operands are non-negative, or 0x800..0 when both are negative. overflow still reports 1; zero is computed on the saturated value; carry is unchanged.
- Undefined: wrapping result, as above.
- Latency is identical in both builds.

Decomposition:
- Package simple_adder_pkg:
  - DEFAULT_WIDTH = 32;
  - a flags typedef struct {carry, overflow, zero};
  - SAT_MAX and SAT_MIN constant functions of WIDTH.
- One sub-module, adder_slice: a parameterised N-bit adder with carry-in and carry-out, used once per stage.

Test Plan:
- Reset held, then in_valid with a=15, b=10 -> 2 cycles later out_valid=1, out=25, carry=0, overflow=0, zero=0.
- a=20, b=-5 (0xFFFFFFFB) -> out=15, carry=1, overflow=0. Then a=-10, b=-5 -> out=0xFFFFFFF1 (-15), carry=1, overflow=0.
- Streamed back-to-back with no gaps, in order: 0+123, 100000+200000, 0x7FFFFFFF+0x80000000 -> consecutive results 123, 300000, 0xFFFFFFFF (carry=0, overflow=0), all with out_valid high.
- Wrap and overflow:
  - 0x7FFFFFFF+1 -> out=0x80000000, overflow=1 (with SIMPLE_ADDER_SAT_EN: out=0x7FFFFFFF, overflow=1);
  - 0x80000000+0x80000000 -> out=0, carry=1, overflow=1, zero=1 (saturated build: out=0x80000000, zero=0).
- Half-boundary carry: 0x0000FFFF+1 -> out=0x00010000, which checks carry propagation from stage 1 into stage 2.
- Assert rst_n low asynchronously one cycle after in_valid -> outputs go to 0 immediately and out_valid never pulses for that operation.

Source files
------------

// File: rtl/simple_adder_pkg.sv
// Shared types and constants for the two-stage pipelined adder.
package simple_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_WIDTH = 256;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } flags_t;

    function automatic logic [MAX_WIDTH-1:0] sat_max(input int w);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < w - 1; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] sat_min(input int w);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        v[w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/simple_adder_slice.sv
// N-bit ripple adder slice with carry-in and carry-out.
module adder_slice
    import simple_adder_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};

endmodule

// File: rtl/simple_adder.sv
// Two-stage pipelined adder with carry/overflow/zero flags.
// Signed saturation on overflow when SIMPLE_ADDER_SAT_EN is defined.
module simple_adder
    import simple_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int LO_WIDTH = WIDTH / 2;
    localparam int HI_WIDTH = WIDTH - LO_WIDTH;

    logic [LO_WIDTH-1:0] lo_nxt;
    logic                c1_nxt;
    logic [LO_WIDTH-1:0] lo_sum;
    logic                c1;
    logic [HI_WIDTH-1:0] a_hi;
    logic [HI_WIDTH-1:0] b_hi;
    logic                v1;

    logic [HI_WIDTH-1:0] hi_sum;
    logic                hi_co;
    logic                ovf;
    logic [WIDTH-1:0]    res;
    flags_t              fl;

    adder_slice #(.N(LO_WIDTH)) u_lo (
        .a   (a[LO_WIDTH-1:0]),
        .b   (b[LO_WIDTH-1:0]),
        .ci  (1'b0),
        .sum (lo_nxt),
        .co  (c1_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_sum <= '0;
            c1     <= 1'b0;
            a_hi   <= '0;
            b_hi   <= '0;
            v1     <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                lo_sum <= lo_nxt;
                c1     <= c1_nxt;
                a_hi   <= a[WIDTH-1:LO_WIDTH];
                b_hi   <= b[WIDTH-1:LO_WIDTH];
            end
        end
    end

    adder_slice #(.N(HI_WIDTH)) u_hi (
        .a   (a_hi),
        .b   (b_hi),
        .ci  (c1),
        .sum (hi_sum),
        .co  (hi_co)
    );

    assign ovf = (a_hi[HI_WIDTH-1] == b_hi[HI_WIDTH-1])
              && (hi_sum[HI_WIDTH-1] != a_hi[HI_WIDTH-1]);

`ifdef SIMPLE_ADDER_SAT_EN
    localparam logic [MAX_WIDTH-1:0] SMAX_F = sat_max(WIDTH);
    localparam logic [MAX_WIDTH-1:0] SMIN_F = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SMAX = SMAX_F[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SMIN = SMIN_F[WIDTH-1:0];

    // Both operands negative saturates low, otherwise high.
    always_comb begin
        res = {hi_sum, lo_sum};
        if (ovf) res = a_hi[HI_WIDTH-1] ? SMIN : SMAX;
    end
`else
    assign res = {hi_sum, lo_sum};
`endif

    assign fl.carry    = hi_co;
    assign fl.overflow = ovf;
    assign fl.zero     = (res == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                out      <= res;
                carry    <= fl.carry;
                overflow <= fl.overflow;
                zero     <= fl.zero;
            end
        end
    end

endmodule

// File: tb/tb_simple_adder.sv
// Directed self-checking bench for simple_adder (32-bit).
module tb_simple_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] out;
    logic        carry;
    logic        overflow;
    logic        zero;

    int checks;
    int errors;

    simple_adder #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out       (out),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op at a negedge; return at the negedge after its result.
    task automatic op(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 32'h1234_5678;
        b = 32'h1111_1111;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out, carry, overflow, zero} !== 36'h0) begin
            errors++;
            $display("FAIL reset: got v=%b out=%h c=%b o=%b z=%b want all 0",
                     out_valid, out, carry, overflow, zero);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_basic;
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'd15;
        b = 32'd10;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out, carry, overflow, zero} !== {1'b1, 32'd25, 3'b000}) begin
            errors++;
            $display("FAIL basic: got v=%b out=%h c=%b o=%b z=%b want 1 00000019 0 0 0",
                     out_valid, out, carry, overflow, zero);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out !== 32'd25) begin
            errors++;
            $display("FAIL basic_hold: v=%b out=%h want 0 00000019", out_valid, out);
        end
    endtask

    task automatic test_signed;
        op(32'd20, 32'hFFFF_FFFB);
        checks++;
        if ({out_valid, out, carry, overflow, zero} !== {1'b1, 32'd15, 3'b100}) begin
            errors++;
            $display("FAIL signed_pos: got v=%b out=%h c=%b o=%b z=%b want 1 0000000f 1 0 0",
                     out_valid, out, carry, overflow, zero);
        end
        op(32'hFFFF_FFF6, 32'hFFFF_FFFB);
        checks++;
        if ({out_valid, out, carry, overflow, zero} !== {1'b1, 32'hFFFF_FFF1, 3'b100}) begin
            errors++;
            $display("FAIL signed_neg: got v=%b out=%h c=%b o=%b z=%b want 1 fffffff1 1 0 0",
                     out_valid, out, carry, overflow, zero);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] xa [3];
        logic [31:0] xb [3];
        logic [31:0] ex [3];
        xa = '{32'd0, 32'd100000, 32'h7FFF_FFFF};
        xb = '{32'd123, 32'd200000, 32'h8000_0000};
        ex = '{32'd123, 32'd300000, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out !== ex[i-2]
                    || carry !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got v=%b out=%h c=%b o=%b z=%b want 1 %h 0 0 0",
                             i - 2, out_valid, out, carry, overflow, zero, ex[i-2]);
                end
            end
            in_valid = (i < 3);
            if (i < 3) begin
                a = xa[i];
                b = xb[i];
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        z2;
`ifdef SIMPLE_ADDER_SAT_EN
        e1 = 32'h7FFF_FFFF;
        e2 = 32'h8000_0000;
        z2 = 1'b0;
`else
        e1 = 32'h8000_0000;
        e2 = 32'h0000_0000;
        z2 = 1'b1;
`endif
        op(32'h7FFF_FFFF, 32'd1);
        checks++;
        if ({out_valid, out, carry, overflow, zero} !== {1'b1, e1, 3'b010}) begin
            errors++;
            $display("FAIL ovf_pos: got v=%b out=%h c=%b o=%b z=%b want 1 %h 0 1 0",
                     out_valid, out, carry, overflow, zero, e1);
        end
        op(32'h8000_0000, 32'h8000_0000);
        checks++;
        if ({out_valid, out, carry, overflow, zero} !== {1'b1, e2, 2'b11, z2}) begin
            errors++;
            $display("FAIL ovf_neg: got v=%b out=%h c=%b o=%b z=%b want 1 %h 1 1 %b",
                     out_valid, out, carry, overflow, zero, e2, z2);
        end
        op(32'hFFFF_FFFF, 32'd1);
        checks++;
        if ({out_valid, out, carry, overflow, zero} !== {1'b1, 32'h0, 3'b101}) begin
            errors++;
            $display("FAIL wrap: got v=%b out=%h c=%b o=%b z=%b want 1 00000000 1 0 1",
                     out_valid, out, carry, overflow, zero);
        end
    endtask

    task automatic test_half_carry;
        op(32'h0000_FFFF, 32'd1);
        checks++;
        if ({out_valid, out, carry, overflow, zero} !== {1'b1, 32'h0001_0000, 3'b000}) begin
            errors++;
            $display("FAIL half_carry: got v=%b out=%h c=%b o=%b z=%b want 1 00010000 0 0 0",
                     out_valid, out, carry, overflow, zero);
        end
    endtask

    task automatic test_async_reset;
        int seen;
        seen = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'd5;
        b = 32'd6;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out, carry, overflow, zero} !== 36'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b out=%h c=%b o=%b z=%b want all 0",
                     out_valid, out, carry, overflow, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL async_no_valid: out_valid pulses=%0d want 0", seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_overflow();
        test_half_carry();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
